frame_color_classifier: RTL and testbench
=========================================

FRAME_COLOR_CLASSIFIER -- requirements
Module: frame_color_classifier

Interface
REQ-001 SHALL have parameter SCREEN_WIDTH, default 176: active pixels per line.
REQ-002 SHALL have parameter SCREEN_HEIGHT, default 144: active lines per frame.
REQ-003 SHALL have parameter NUM_BANDS, default 3: horizontal bands; odd, >=3, divides SCREEN_HEIGHT.
REQ-004 SHALL have parameter COUNT_W, default 16: width of every pixel counter.
REQ-005 SHALL have parameter THRESH, default 2000: minimum frame pixel count for a colour decision.
REQ-006 SHALL have port CLK, input, 1 bit: the single clock; all logic is posedge CLK.
REQ-007 SHALL have port RESET, input, 1 bit: asynchronous, active-high reset.
REQ-008 SHALL have port PIXEL_IN, input, 8 bits: RGB332 pixel, R[7:5] G[4:2] B[1:0].
REQ-009 SHALL have port HREF, input, 1 bit: pixel valid, high during an active line.
REQ-010 SHALL have port VSYNC, input, 1 bit: frame sync, high between frames.
REQ-011 SHALL have port RESULT, output, 4 bits: [1:0] colour (00 none, 01 red, 10 blue), [3:2] shape (00 none, 01 square, 10 triangle, 11 diamond).
REQ-012 SHALL have port RESULT_VALID, output, 1 bit: one-cycle pulse when RESULT updates.

Function
REQ-013 SHALL register VSYNC and HREF once and detect edges against the registered copies.
REQ-014 SHALL use states WAIT_FRAME, ACTIVE and DECIDE; after reset it enters WAIT_FRAME.
REQ-015 WAIT_FRAME -> ACTIVE on VSYNC falling edge; ACTIVE -> DECIDE on VSYNC rising edge; DECIDE -> WAIT_FRAME after one cycle.
REQ-016 On entry to ACTIVE it SHALL clear all counters, the x counter, the y counter and the band index.
REQ-017 In ACTIVE with HREF=1 it SHALL increment x; on an HREF falling edge it SHALL clear x and increment y.
REQ-018 The band index SHALL advance every SCREEN_HEIGHT/NUM_BANDS lines using a line-in-band counter, with no divider.
REQ-019 Pixels with x>=SCREEN_WIDTH or y>=SCREEN_HEIGHT SHALL be ignored.
REQ-020 Classification: red if R>=5 and B<=1 and G<=3; blue if B>=2 and R<=2 and G<=3; otherwise neither.
REQ-021 It SHALL keep per-band red and blue counters that saturate at 2^COUNT_W-1 and never wrap.
REQ-022 Frame totals SHALL be saturating sums of the per-band counters.
REQ-023 In DECIDE, colour SHALL be red if totR>THRESH and totR>=totB (a tie resolves to red), blue if totB>THRESH and totB>totR, else none.
REQ-024 Shape SHALL use the winning colour's counts in band T (0), band M (NUM_BANDS/2) and band B (NUM_BANDS-1).
REQ-025 Shape SHALL be triangle if 2B>3T, diamond if 2M>3T and 2M>3B, else square, with triangle taking priority.
REQ-026 Shape SHALL be 00 whenever colour is none.
REQ-027 RESULT SHALL update and RESULT_VALID SHALL pulse exactly 2 cycles after the first CLK edge at which VSYNC is sampled high.
REQ-028 RESULT SHALL hold its value between frames.
REQ-029 A VSYNC rising edge in WAIT_FRAME SHALL produce no result and no pulse.
REQ-030 HREF while VSYNC=1 SHALL be ignored.

Reset
REQ-031 RESET SHALL asynchronously force RESULT=0, RESULT_VALID=0, all counters to 0 and the state to WAIT_FRAME.
REQ-032 A frame interrupted by reset SHALL be discarded; counting resumes only after the next VSYNC falling edge.

Configuration
REQ-033 The macro FCC_SHAPE_DETECT_EN SHALL control shape detection.
REQ-034 When FCC_SHAPE_DETECT_EN is defined, per-band counters and the REQ-025 shape logic SHALL be built.
REQ-035 When FCC_SHAPE_DETECT_EN is undefined, only frame-total red/blue counters SHALL exist and RESULT[3:2] SHALL be constant 00.

Structure
REQ-036 A shared package fcc_pkg SHALL hold the colour codes, shape codes, state encoding and the RGB332 field positions.
REQ-037 One sub-module, fcc_band_counter, SHALL hold one band's saturating red and blue counters with a clear and an enable; it SHALL be instantiated NUM_BANDS times.

Verification
REQ-038 All-red frame, 176x144 of 8'hE0 -> RESULT=4'b0101 (red, square), RESULT_VALID high for exactly 1 cycle, 2 cycles after VSYNC rises.
REQ-039 Blue triangle of 8'h03 pixels with widths 20/60/100 per row in bands 0/1/2 -> RESULT=4'b1010.
REQ-040 Red diamond with band counts 500/3000/500 -> RESULT=4'b1101; the same frame built without FCC_SHAPE_DETECT_EN -> 4'b0001.
REQ-041 Frame of 1500 red pixels (below THRESH) -> RESULT=4'b0000; a red/blue tie at 2500 each -> colour 01.
REQ-042 RESET asserted mid-frame, then VSYNC rises -> no RESULT_VALID pulse and RESULT=0; the next full frame classifies normally.
REQ-043 COUNT_W=8 with an all-red frame -> counters saturate at 255 without wrapping; with THRESH=100, RESULT colour is 01.

Source files
------------

// File: rtl/fcc_pkg.sv
// Shared definitions for frame_color_classifier: FSM states, RESULT colour and
// shape codes, RGB332 field positions and the per-pixel colour classifiers.
package fcc_pkg;

    typedef enum logic [1:0] {
        WAIT_FRAME = 2'd0,
        ACTIVE     = 2'd1,
        DECIDE     = 2'd2
    } fcc_state_e;

    typedef enum logic [1:0] {
        COLOR_NONE = 2'b00,
        COLOR_RED  = 2'b01,
        COLOR_BLUE = 2'b10
    } fcc_color_e;

    typedef enum logic [1:0] {
        SHAPE_NONE     = 2'b00,
        SHAPE_SQUARE   = 2'b01,
        SHAPE_TRIANGLE = 2'b10,
        SHAPE_DIAMOND  = 2'b11
    } fcc_shape_e;

    localparam int R_MSB = 7;
    localparam int R_LSB = 5;
    localparam int G_MSB = 4;
    localparam int G_LSB = 2;
    localparam int B_MSB = 1;
    localparam int B_LSB = 0;

    function automatic logic is_red_px(input logic [7:0] px);
        return (px[R_MSB:R_LSB] >= 3'd5) && (px[B_MSB:B_LSB] <= 2'd1) &&
               (px[G_MSB:G_LSB] <= 3'd3);
    endfunction

    function automatic logic is_blue_px(input logic [7:0] px);
        return (px[B_MSB:B_LSB] >= 2'd2) && (px[R_MSB:R_LSB] <= 3'd2) &&
               (px[G_MSB:G_LSB] <= 3'd3);
    endfunction

endpackage

// File: rtl/fcc_band_counter.sv
// One band's saturating red/blue pixel counters with synchronous clear and
// count enable.
module fcc_band_counter #(
    parameter int COUNT_W = 16
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               clr,
    input  logic               en,
    input  logic               is_red,
    input  logic               is_blue,
    output logic [COUNT_W-1:0] red_cnt,
    output logic [COUNT_W-1:0] blue_cnt
);

    logic [COUNT_W-1:0] red_q, red_d;
    logic [COUNT_W-1:0] blue_q, blue_d;

    always_comb begin
        red_d  = red_q;
        blue_d = blue_q;
        if (clr) begin
            red_d  = '0;
            blue_d = '0;
        end else if (en) begin
            // Counters hold at all-ones rather than wrapping.
            if (is_red && (red_q != '1))
                red_d = red_q + COUNT_W'(1);
            if (is_blue && (blue_q != '1))
                blue_d = blue_q + COUNT_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of block evaluation order.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            red_q  <= '0;
            blue_q <= '0;
        end else begin
            red_q  <= red_d;
            blue_q <= blue_d;
        end
    end

    assign red_cnt  = red_q;
    assign blue_cnt = blue_q;

endmodule

// File: rtl/frame_color_classifier.sv
// Per-frame red/blue colour classifier with optional band-based shape detection,
// built only when FCC_SHAPE_DETECT_EN is defined.
module frame_color_classifier
    import fcc_pkg::*;
#(
    parameter int          SCREEN_WIDTH  = 176,
    parameter int          SCREEN_HEIGHT = 144,
    parameter int          NUM_BANDS     = 3,
    parameter int          COUNT_W       = 16,
    parameter int unsigned THRESH        = 2000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [7:0] PIXEL_IN,
    input  logic       HREF,
    input  logic       VSYNC,
    output logic [3:0] RESULT,
    output logic       RESULT_VALID
);

    localparam int LINES_PER_BAND = SCREEN_HEIGHT / NUM_BANDS;
    // Equals SCREEN_HEIGHT because NUM_BANDS divides it.
    localparam int Y_LINES = LINES_PER_BAND * NUM_BANDS;
    localparam int XW      = $clog2(SCREEN_WIDTH + 1);
    localparam int YW      = $clog2(Y_LINES + 1);
    localparam logic [XW-1:0] X_LIMIT  = XW'(SCREEN_WIDTH);
    localparam logic [YW-1:0] Y_LIMIT  = YW'(Y_LINES);
    localparam logic [31:0]   THRESH_V = 32'(THRESH);

    fcc_state_e         state_q, state_d;
    logic               vsync_q, href_q;
    logic [XW-1:0]      x_q, x_d;
    logic [YW-1:0]      y_q, y_d;
    fcc_color_e         color_q, color_d, color_dec;
    fcc_shape_e         shape_q, shape_d, shape_dec;
    logic               dec_valid_q, dec_valid_d;
    logic [3:0]         result_q, result_d;
    logic               result_valid_q, result_valid_d;
    logic [COUNT_W-1:0] tot_red, tot_blue;
    logic               vs_rise, vs_fall, href_fall, frame_start, line_active, pix_en;
    logic               px_red, px_blue;

    assign vs_rise     = VSYNC & ~vsync_q;
    assign vs_fall     = ~VSYNC & vsync_q;
    assign href_fall   = ~HREF & href_q;
    assign frame_start = (state_q == WAIT_FRAME) && vs_fall;
    // HREF is only meaningful inside a frame, i.e. while VSYNC is low.
    assign line_active = (state_q == ACTIVE) && !VSYNC;
    assign pix_en      = line_active && HREF && (x_q < X_LIMIT) && (y_q < Y_LIMIT);
    assign px_red      = is_red_px(PIXEL_IN);
    assign px_blue     = is_blue_px(PIXEL_IN);

    always_comb begin
        state_d = state_q;
        case (state_q)
            WAIT_FRAME: if (vs_fall) state_d = ACTIVE;
            ACTIVE:     if (vs_rise) state_d = DECIDE;
            DECIDE:     state_d = WAIT_FRAME;
            default:    state_d = WAIT_FRAME;
        endcase
    end

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (frame_start) begin
            x_d = '0;
            y_d = '0;
        end else if (line_active) begin
            if (HREF) begin
                if (x_q != X_LIMIT) x_d = x_q + XW'(1);
            end else if (href_q) begin
                x_d = '0;
                if (y_q != Y_LIMIT) y_d = y_q + YW'(1);
            end
        end
    end

`ifdef FCC_SHAPE_DETECT_EN
    localparam int BAND_W = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1;
    localparam int LINE_W = (LINES_PER_BAND > 1) ? $clog2(LINES_PER_BAND) : 1;
    localparam int SUM_W  = COUNT_W + $clog2(NUM_BANDS) + 1;
    localparam int PROD_W = COUNT_W + 2;
    localparam logic [SUM_W-1:0] SUM_SAT = SUM_W'({COUNT_W{1'b1}});

    logic [BAND_W-1:0]  band_q, band_d;
    logic [LINE_W-1:0]  line_q, line_d;
    logic [COUNT_W-1:0] band_red  [NUM_BANDS];
    logic [COUNT_W-1:0] band_blue [NUM_BANDS];
    logic [SUM_W-1:0]   sum_red, sum_blue;
    logic [COUNT_W-1:0] cnt_t, cnt_m, cnt_b;
    logic [PROD_W-1:0]  t3, m2, b2, b3;

    // Band tracking counts lines within the band instead of dividing y.
    always_comb begin
        band_d = band_q;
        line_d = line_q;
        if (frame_start) begin
            band_d = '0;
            line_d = '0;
        end else if (line_active && href_fall) begin
            if (line_q == LINE_W'(LINES_PER_BAND - 1)) begin
                line_d = '0;
                if (band_q != BAND_W'(NUM_BANDS - 1)) band_d = band_q + BAND_W'(1);
            end else begin
                line_d = line_q + LINE_W'(1);
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            band_q <= '0;
            line_q <= '0;
        end else begin
            band_q <= band_d;
            line_q <= line_d;
        end
    end

    for (genvar i = 0; i < NUM_BANDS; i++) begin : g_band
        fcc_band_counter #(.COUNT_W(COUNT_W)) u_cnt (
            .CLK      (CLK),
            .RESET    (RESET),
            .clr      (frame_start),
            .en       (pix_en && (band_q == BAND_W'(i))),
            .is_red   (px_red),
            .is_blue  (px_blue),
            .red_cnt  (band_red[i]),
            .blue_cnt (band_blue[i])
        );
    end

    always_comb begin
        sum_red  = '0;
        sum_blue = '0;
        for (int i = 0; i < NUM_BANDS; i++) begin
            sum_red  = sum_red  + SUM_W'(band_red[i]);
            sum_blue = sum_blue + SUM_W'(band_blue[i]);
        end
        tot_red  = (sum_red  > SUM_SAT) ? '1 : sum_red[COUNT_W-1:0];
        tot_blue = (sum_blue > SUM_SAT) ? '1 : sum_blue[COUNT_W-1:0];
    end

    always_comb begin
        if (color_dec == COLOR_BLUE) begin
            cnt_t = band_blue[0];
            cnt_m = band_blue[NUM_BANDS/2];
            cnt_b = band_blue[NUM_BANDS-1];
        end else begin
            cnt_t = band_red[0];
            cnt_m = band_red[NUM_BANDS/2];
            cnt_b = band_red[NUM_BANDS-1];
        end
        t3 = (PROD_W'(cnt_t) << 1) + PROD_W'(cnt_t);
        m2 = PROD_W'(cnt_m) << 1;
        b2 = PROD_W'(cnt_b) << 1;
        b3 = b2 + PROD_W'(cnt_b);
        shape_dec = SHAPE_NONE;
        if (color_dec != COLOR_NONE) begin
            if (b2 > t3)                      shape_dec = SHAPE_TRIANGLE;
            else if ((m2 > t3) && (m2 > b3))  shape_dec = SHAPE_DIAMOND;
            else                              shape_dec = SHAPE_SQUARE;
        end
    end
`else
    fcc_band_counter #(.COUNT_W(COUNT_W)) u_frame_cnt (
        .CLK      (CLK),
        .RESET    (RESET),
        .clr      (frame_start),
        .en       (pix_en),
        .is_red   (px_red),
        .is_blue  (px_blue),
        .red_cnt  (tot_red),
        .blue_cnt (tot_blue)
    );

    assign shape_dec = SHAPE_NONE;
`endif

    // Ties go to red.
    always_comb begin
        color_dec = COLOR_NONE;
        if ((32'(tot_red) > THRESH_V) && (tot_red >= tot_blue))
            color_dec = COLOR_RED;
        else if ((32'(tot_blue) > THRESH_V) && (tot_blue > tot_red))
            color_dec = COLOR_BLUE;
    end

    always_comb begin
        color_d     = color_q;
        shape_d     = shape_q;
        dec_valid_d = 1'b0;
        if (state_q == DECIDE) begin
            color_d     = color_dec;
            shape_d     = shape_dec;
            dec_valid_d = 1'b1;
        end
        result_d       = result_q;
        result_valid_d = dec_valid_q;
        if (dec_valid_q) result_d = {shape_q, color_q};
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q        <= WAIT_FRAME;
            vsync_q        <= 1'b0;
            href_q         <= 1'b0;
            x_q            <= '0;
            y_q            <= '0;
            color_q        <= COLOR_NONE;
            shape_q        <= SHAPE_NONE;
            dec_valid_q    <= 1'b0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            vsync_q        <= VSYNC;
            href_q         <= HREF;
            x_q            <= x_d;
            y_q            <= y_d;
            color_q        <= color_d;
            shape_q        <= shape_d;
            dec_valid_q    <= dec_valid_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
        end
    end

    assign RESULT       = result_q;
    assign RESULT_VALID = result_valid_q;

endmodule

// File: tb/tb_frame_color_classifier.sv
// Self-checking bench for frame_color_classifier: default-size DUT plus a
// COUNT_W=8 / THRESH=100 DUT on the same stimulus, both against a pixel-level model.
module tb_frame_color_classifier;

    localparam int W   = 176;
    localparam int H   = 144;
    localparam int NB  = 3;
    localparam int LPB = H / NB;
    localparam int CW1 = 16;
    localparam int TH1 = 2000;
    localparam int CW2 = 8;
    localparam int TH2 = 100;

    localparam int K_ALLRED = 0;
    localparam int K_TRI    = 1;
    localparam int K_DIAM   = 2;
    localparam int K_LOW    = 3;
    localparam int K_TIE    = 4;
    localparam int K_RAND   = 5;

`ifdef FCC_SHAPE_DETECT_EN
    localparam bit SHAPE_EN = 1'b1;
`else
    localparam bit SHAPE_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] pixel;
    logic       href;
    logic       vsync;
    logic [3:0] result, result_s;
    logic       result_valid, result_valid_s;

    int n_checks = 0;
    int n_fail   = 0;
    int m_red  [NB];
    int m_blue [NB];
    int rand_pr;
    int rand_pb;

    always #5 clk = ~clk;

    frame_color_classifier dut (
        .CLK          (clk),
        .RESET        (rst),
        .PIXEL_IN     (pixel),
        .HREF         (href),
        .VSYNC        (vsync),
        .RESULT       (result),
        .RESULT_VALID (result_valid)
    );

    frame_color_classifier #(.COUNT_W(CW2), .THRESH(TH2)) dut_small (
        .CLK          (clk),
        .RESET        (rst),
        .PIXEL_IN     (pixel),
        .HREF         (href),
        .VSYNC        (vsync),
        .RESULT       (result_s),
        .RESULT_VALID (result_valid_s)
    );

    // ---------------- reference model ----------------
    function automatic bit px_red(input logic [7:0] p);
        int v = int'(p);
        return (v / 32 >= 5) && (v % 4 <= 1) && ((v / 4) % 8 <= 3);
    endfunction

    function automatic bit px_blue(input logic [7:0] p);
        int v = int'(p);
        return (v % 4 >= 2) && (v / 32 <= 2) && ((v / 4) % 8 <= 3);
    endfunction

    task automatic model_pixel(input int x, input int y, input logic [7:0] p);
        if (x < W && y < H) begin
            if (px_red(p))       m_red[y / LPB]++;
            else if (px_blue(p)) m_blue[y / LPB]++;
        end
    endtask

    function automatic logic [3:0] model_result(input int cw, input int thr);
        longint mx, tr, tb, t, m, bt;
        longint r [NB];
        longint b [NB];
        logic [1:0] col, shp;
        mx = (longint'(1) << cw) - 1;
        tr = 0;
        tb = 0;
        for (int i = 0; i < NB; i++) begin
            r[i] = (m_red[i]  > mx) ? mx : longint'(m_red[i]);
            b[i] = (m_blue[i] > mx) ? mx : longint'(m_blue[i]);
            tr += r[i];
            tb += b[i];
        end
        if (tr > mx) tr = mx;
        if (tb > mx) tb = mx;
        col = 2'b00;
        if (tr > thr && tr >= tb)      col = 2'b01;
        else if (tb > thr && tb > tr)  col = 2'b10;
        shp = 2'b00;
        if (SHAPE_EN && col != 2'b00) begin
            if (col == 2'b01) begin t = r[0]; m = r[NB/2]; bt = r[NB-1]; end
            else              begin t = b[0]; m = b[NB/2]; bt = b[NB-1]; end
            if (2 * bt > 3 * t)                         shp = 2'b10;
            else if (2 * m > 3 * t && 2 * m > 3 * bt)   shp = 2'b11;
            else                                        shp = 2'b01;
        end
        return {shp, col};
    endfunction

    // ---------------- frame recipes ----------------
    function automatic int gen_len(input int kind, input int y);
        case (kind)
            K_ALLRED: return W;
            K_TRI:    return (y < LPB) ? 20 : ((y < 2 * LPB) ? 60 : 100);
            K_DIAM: begin
                if (y < 10)                             return 50;
                else if (y >= LPB && y < LPB + 20)      return 150;
                else if (y >= 2 * LPB && y < 2 * LPB + 10) return 50;
                else                                    return 1;
            end
            K_LOW:    return (y < 15) ? 100 : 1;
            K_TIE:    return (y < 50) ? 100 : 1;
            default:  return (y % 37 == 5) ? int'($urandom_range(185, 170))
                                           : int'($urandom_range(40, 1));
        endcase
    endfunction

    function automatic logic [7:0] gen_pixel(input int kind, input int y, input int len);
        int sel;
        case (kind)
            K_ALLRED: return 8'hE0;
            K_TRI:    return 8'h03;
            K_DIAM,
            K_LOW:    return (len > 1) ? 8'hE0 : 8'h00;
            K_TIE:    return (y < 25) ? 8'hE0 : ((y < 50) ? 8'h03 : 8'h00);
            default: begin
                sel = int'($urandom_range(99, 0));
                if (sel < rand_pr)
                    return {3'($urandom_range(7, 5)), 3'($urandom_range(3, 0)), 2'($urandom_range(1, 0))};
                else if (sel < rand_pr + rand_pb)
                    return {3'($urandom_range(2, 0)), 3'($urandom_range(3, 0)), 2'($urandom_range(3, 2))};
                else
                    return 8'($urandom);
            end
        endcase
    endfunction

    // ---------------- drivers (entered and left just after a negedge) ----------------
    task automatic start_frame();
        vsync = 1'b1;
        href  = 1'b0;
        repeat (3) @(negedge clk);
        vsync = 1'b0;
        for (int i = 0; i < NB; i++) begin
            m_red[i]  = 0;
            m_blue[i] = 0;
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic send_line(input int kind, input int y, input int len);
        for (int x = 0; x < len; x++) begin
            logic [7:0] p;
            p     = gen_pixel(kind, y, len);
            pixel = p;
            href  = 1'b1;
            model_pixel(x, y, p);
            @(negedge clk);
        end
        href  = 1'b0;
        pixel = 8'h00;
        repeat (2) @(negedge clk);
    endtask

    task automatic finish_frame(input string name);
        logic [3:0] exp_main, exp_small;
        exp_main  = model_result(CW1, TH1);
        exp_small = model_result(CW2, TH2);
        vsync = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            n_checks++;
            if (result_valid !== 1'(k == 2)) begin
                n_fail++;
                $display("FAIL %s valid cycle %0d: got %b expected %b", name, k, result_valid, k == 2);
            end
            n_checks++;
            if (result_valid_s !== 1'(k == 2)) begin
                n_fail++;
                $display("FAIL %s small valid cycle %0d: got %b expected %b", name, k, result_valid_s, k == 2);
            end
            if (k == 2) begin
                n_checks++;
                if (result !== exp_main) begin
                    n_fail++;
                    $display("FAIL %s result: got %b expected %b", name, result, exp_main);
                end
                n_checks++;
                if (result_s !== exp_small) begin
                    n_fail++;
                    $display("FAIL %s small result: got %b expected %b", name, result_s, exp_small);
                end
            end
        end
        repeat (4) @(negedge clk);
        n_checks++;
        if (result !== exp_main) begin
            n_fail++;
            $display("FAIL %s hold: got %b expected %b", name, result, exp_main);
        end
    endtask

    task automatic run_frame(input int kind, input string name);
        int rows;
        rows = (kind == K_RAND) ? int'($urandom_range(150, 140)) : H;
        start_frame();
        for (int y = 0; y < rows; y++) send_line(kind, y, gen_len(kind, y));
        finish_frame(name);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst   = 1'b1;
        vsync = 1'b1;
        href  = 1'b0;
        pixel = 8'h00;
        repeat (3) @(negedge clk);
        n_checks++;
        if (result !== 4'b0000 || result_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset outputs: got %b/%b expected 0000/0", result, result_valid);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (result_s !== 4'b0000 || result_valid_s !== 1'b0) begin
            n_fail++;
            $display("FAIL reset small outputs: got %b/%b expected 0000/0", result_s, result_valid_s);
        end
    endtask

    task automatic test_reset_mid_frame();
        start_frame();
        for (int y = 0; y < 20; y++) send_line(K_LOW, y, 100);
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (result !== 4'b0000 || result_valid !== 1'b0 || result_s !== 4'b0000) begin
            n_fail++;
            $display("FAIL async reset: got %b/%b/%b expected 0000/0/0000", result, result_valid, result_s);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int y = 20; y < 40; y++) send_line(K_LOW, y, 100);
        vsync = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            n_checks++;
            if (result_valid !== 1'b0 || result_valid_s !== 1'b0) begin
                n_fail++;
                $display("FAIL discarded frame pulse cycle %0d: got %b/%b expected 0/0", k, result_valid, result_valid_s);
            end
        end
        n_checks++;
        if (result !== 4'b0000) begin
            n_fail++;
            $display("FAIL discarded frame result: got %b expected 0000", result);
        end
        run_frame(K_DIAM, "after_reset");
    endtask

    task automatic test_random();
        for (int i = 0; i < 4; i++) begin
            case (i)
                0:       begin rand_pr = 70; rand_pb = 10; end
                1:       begin rand_pr = 10; rand_pb = 70; end
                2:       begin rand_pr = 40; rand_pb = 40; end
                default: begin rand_pr = 25; rand_pb = 5;  end
            endcase
            run_frame(K_RAND, $sformatf("random%0d", i));
        end
    endtask

    initial begin
        rand_pr = 0;
        rand_pb = 0;
        test_reset();
        run_frame(K_ALLRED, "all_red");
        run_frame(K_TRI,    "blue_triangle");
        run_frame(K_DIAM,   "red_diamond");
        run_frame(K_LOW,    "below_thresh");
        run_frame(K_TIE,    "red_blue_tie");
        test_reset_mid_frame();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
